rx_deframer: RTL and testbench
==============================

RX_DEFRAMER -- requirements
Module: rx_deframer

Interface
REQ-001 SHALL have parameter MIN_BYTES, default 3, minimum byte count (FCS included) for a valid frame.
REQ-002 SHALL have port Clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port RxEn  input  1  qualifies Rx; one serial bit consumed per cycle with RxEn=1.
REQ-005 SHALL have port Rx  input  1  raw serial HDLC line bit.
REQ-006 SHALL have port DataBuff  output  8  assembled received byte, valid while WrBuff=1.
REQ-007 SHALL have port WrBuff  output  1  one-cycle pulse per assembled byte.
REQ-008 SHALL have port FlagDetect  output  1  one-cycle pulse per detected flag 0x7E.
REQ-009 SHALL have port EoF  output  1  one-cycle pulse, valid frame closed.
REQ-010 SHALL have port FrameError  output  1  one-cycle pulse, closed frame invalid.
REQ-011 SHALL have port AbortedFrame  output  1  one-cycle pulse, abort inside a frame.
REQ-012 SHALL have port Active  output  1  high while state is FRAME.

Function
REQ-013 SHALL implement states HUNT, SYNC and FRAME, and SHALL ignore Rx in cycles with RxEn=0 without changing state or counters.
REQ-014 SHALL detect a flag when the last 8 raw bits, oldest first, are 0,1,1,1,1,1,1,0, in any state; FlagDetect is high the cycle after the final flag bit is sampled.
REQ-015 SHALL, in SYNC and FRAME, discard a raw 0 that immediately follows exactly five consecutive 1s (destuffing); in HUNT, no bits are discarded.
REQ-016 SHALL pass destuffed bits through an 8-stage delay line, clearing it on every flag, and SHALL feed a bit to the byte assembler only when it is shifted out of a full delay line, so that flag bits never reach data.
REQ-017 SHALL assemble bytes LSB-first; when the 8th bit enters, DataBuff SHALL hold the byte and WrBuff SHALL be high the following cycle.
REQ-018 SHALL count bytes per frame in 8 bits, saturating at 255; WrBuff SHALL NOT be suppressed at any count, because overflow is the buffer's job.
REQ-019 SHALL transition as follows:
  - HUNT->SYNC on a flag.
  - SYNC->SYNC on a flag.
  - SYNC->FRAME when the first bit leaves the delay line.
  - FRAME->SYNC on the closing flag, which also opens the next frame.
REQ-020 SHALL, on the closing flag, assert exactly one of EoF or FrameError the cycle after FlagDetect, so that it always follows the frame's last WrBuff by at least one cycle.
REQ-021 SHALL raise FrameError if the assembler holds a partial byte (1-7 bits) or if byte count < MIN_BYTES at closing; otherwise it SHALL raise EoF.
REQ-022 SHALL, on 7 consecutive raw 1s in FRAME, pulse AbortedFrame the next cycle, discard the partial byte and delay line, and go to HUNT without EoF or FrameError.
REQ-023 SHALL, on 7 consecutive 1s in SYNC, go to HUNT silently; continuous 1s (idle) SHALL keep the state in HUNT.
REQ-024 SHALL NOT assert WrBuff for bits received after an abort until a new flag is detected.
REQ-025 SHALL keep EoF, FrameError and AbortedFrame mutually exclusive in any cycle.

Reset
REQ-026 SHALL, with Rst=0 at a clock edge, set all outputs to 0, state to HUNT, and clear the shift register, delay line, ones counter, bit counter and byte counter.
REQ-027 SHALL NOT emit EoF, FrameError or AbortedFrame for a frame interrupted by reset.

Configuration
REQ-028 SHALL, with RX_FCS_CHECK_EN defined, compute CRC-16-CCITT (reflected, preset 0xFFFF) over all assembled bytes, including FCS, of the frame, and SHALL re-preset it on each flag.
REQ-029 SHALL, with RX_FCS_CHECK_EN defined, raise FrameError instead of EoF at closing when the residue is not 0xF0B8.
REQ-030 SHALL, without RX_FCS_CHECK_EN, contain no CRC logic, and FrameError SHALL depend only on REQ-021.

Verification
REQ-031 SHALL cover a valid frame: flag, bytes A5 3C 7E plus correct FCS (stuffed), flag -> WrBuff x5 with DataBuff A5,3C,7E,FCS_lo,FCS_hi; EoF=1 one cycle after FlagDetect; FrameError=0.
REQ-032 SHALL cover destuffing: frame containing 0xFF (stuffed 0 after bit 5) -> DataBuff=0xFF with no extra bit consumed.
REQ-033 SHALL cover abort: flag, 0x55, then seven 1s -> AbortedFrame one pulse, no EoF/FrameError, Active=0; a following flag plus valid frame -> EoF.
REQ-034 SHALL cover length and alignment errors: flag, 0x11 0x22, flag -> FrameError; flag, 0x55 x3 plus 3 bits, flag -> FrameError; no EoF in either case.
REQ-035 SHALL cover FCS: with RX_FCS_CHECK_EN, a corrupted FCS byte -> FrameError; without it, the same stimulus -> EoF.
REQ-036 SHALL cover flow control: back-to-back frames sharing one flag with RxEn toggled 1,0,1,0 -> same byte/EoF sequence as with RxEn held at 1; Rst=0 mid-frame -> all outputs 0 next cycle and no further pulses.

Source files
------------

// File: rtl/rx_deframer.sv
// HDLC receive deframer: flag hunt, zero-bit destuffing, LSB-first byte assembly, abort/length checks.
// Optional CRC-16-CCITT frame check sequence verification is built when RX_FCS_CHECK_EN is defined.
module rx_deframer #(
    parameter int MIN_BYTES = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RxEn,
    input  logic       Rx,
    output logic [7:0] DataBuff,
    output logic       WrBuff,
    output logic       FlagDetect,
    output logic       EoF,
    output logic       FrameError,
    output logic       AbortedFrame,
    output logic       Active
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SYNC  = 2'd1,
        FRAME = 2'd2
    } state_t;

    localparam logic [8:0] MIN_CNT = 9'(MIN_BYTES);

    state_t      state;
    state_t      state_nx;

    logic [6:0]  raw_sr;
    logic [2:0]  ones;
    logic [7:0]  dly;
    logic [3:0]  dly_cnt;
    logic [7:0]  asm_sr;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_cnt;
    logic        close_pend;
    logic        close_err;

    logic [7:0]  raw_nx;
    logic        flag;
    logic        abort;
    logic        stuffed;
    logic        dbit_vld;
    logic        dout_vld;
    logic        in_frame;
    logic [7:0]  asm_nx;
    logic [2:0]  bit_cnt_nx;
    logic        byte_done;
    logic [7:0]  byte_cnt_nx;
    logic        close;
    logic        bad_close;

`ifdef RX_FCS_CHECK_EN
    logic [15:0] crc;
    logic [15:0] crc_nx;
`endif

    always_comb begin
        raw_nx      = {raw_sr, Rx};
        flag        = RxEn && (raw_nx == 8'h7E);
        abort       = RxEn && Rx && (ones == 3'd6);
        stuffed     = RxEn && !Rx && (ones == 3'd5) && (state != HUNT);
        dbit_vld    = RxEn && (state != HUNT) && !stuffed && !abort;
        // A bit reaches the assembler only once eight newer bits sit behind it,
        // so the eight bits of a closing flag are always still in the line.
        dout_vld    = dbit_vld && (dly_cnt == 4'd8);
        in_frame    = (state == FRAME) || ((state == SYNC) && dout_vld);
        asm_nx      = {dly[7], asm_sr[7:1]};
        bit_cnt_nx  = dout_vld ? bit_cnt + 3'd1 : bit_cnt;
        byte_done   = dout_vld && (bit_cnt == 3'd7);
        byte_cnt_nx = (byte_done && (byte_cnt != 8'hFF)) ? byte_cnt + 8'd1 : byte_cnt;
        close       = flag && in_frame;
        bad_close   = (bit_cnt_nx != 3'd0) || ({1'b0, byte_cnt_nx} < MIN_CNT);
`ifdef RX_FCS_CHECK_EN
        crc_nx = crc;
        if (dout_vld)
            crc_nx = {1'b0, crc[15:1]} ^ ((crc[0] ^ dly[7]) ? 16'h8408 : 16'h0000);
        if (crc_nx != 16'hF0B8)
            bad_close = 1'b1;
`endif

        state_nx = state;
        if (RxEn) begin
            case (state)
                HUNT: begin
                    if (flag)
                        state_nx = SYNC;
                end
                SYNC: begin
                    if (abort)
                        state_nx = HUNT;
                    else if (flag)
                        state_nx = SYNC;
                    else if (dout_vld)
                        state_nx = FRAME;
                end
                FRAME: begin
                    if (abort)
                        state_nx = HUNT;
                    else if (flag)
                        state_nx = SYNC;
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state        <= HUNT;
            raw_sr       <= '0;
            ones         <= '0;
            dly          <= '0;
            dly_cnt      <= '0;
            asm_sr       <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            close_pend   <= 1'b0;
            close_err    <= 1'b0;
            DataBuff     <= '0;
            WrBuff       <= 1'b0;
            FlagDetect   <= 1'b0;
            EoF          <= 1'b0;
            FrameError   <= 1'b0;
            AbortedFrame <= 1'b0;
`ifdef RX_FCS_CHECK_EN
            crc          <= 16'hFFFF;
`endif
        end else begin
            state        <= state_nx;
            WrBuff       <= 1'b0;
            AbortedFrame <= 1'b0;
            FlagDetect   <= flag;
            // Closing verdict is held one cycle so it lands after FlagDetect
            // and after any byte completed by the flag's final bit.
            EoF          <= close_pend && !close_err;
            FrameError   <= close_pend && close_err;
            close_pend   <= 1'b0;

            if (RxEn) begin
                raw_sr <= raw_nx[6:0];
                ones   <= !Rx ? 3'd0 : (ones == 3'd7) ? 3'd7 : ones + 3'd1;

                if (abort) begin
                    dly          <= '0;
                    dly_cnt      <= '0;
                    asm_sr       <= '0;
                    bit_cnt      <= '0;
                    byte_cnt     <= '0;
                    AbortedFrame <= (state == FRAME);
`ifdef RX_FCS_CHECK_EN
                    crc          <= 16'hFFFF;
`endif
                end else begin
                    if (dout_vld) begin
                        asm_sr   <= asm_nx;
                        bit_cnt  <= bit_cnt_nx;
                        byte_cnt <= byte_cnt_nx;
`ifdef RX_FCS_CHECK_EN
                        crc      <= crc_nx;
`endif
                        if (byte_done) begin
                            DataBuff <= asm_nx;
                            WrBuff   <= 1'b1;
                        end
                    end

                    if (dbit_vld) begin
                        dly     <= {dly[6:0], Rx};
                        dly_cnt <= (dly_cnt == 4'd8) ? 4'd8 : dly_cnt + 4'd1;
                    end

                    if (flag) begin
                        dly        <= '0;
                        dly_cnt    <= '0;
                        asm_sr     <= '0;
                        bit_cnt    <= '0;
                        byte_cnt   <= '0;
                        close_pend <= close;
                        close_err  <= bad_close;
`ifdef RX_FCS_CHECK_EN
                        crc        <= 16'hFFFF;
`endif
                    end
                end
            end
        end
    end

    assign Active = (state == FRAME);

endmodule

// File: tb/tb_rx_deframer.sv
// Directed bench for rx_deframer: a table of frames plus abort, reset and RxEn-gap sequences.
module tb_rx_deframer;

    logic       Clk;
    logic       Rst;
    logic       RxEn;
    logic       Rx;
    logic [7:0] DataBuff;
    logic       WrBuff;
    logic       FlagDetect;
    logic       EoF;
    logic       FrameError;
    logic       AbortedFrame;
    logic       Active;

    rx_deframer #(.MIN_BYTES(3)) dut (
        .Clk(Clk), .Rst(Rst), .RxEn(RxEn), .Rx(Rx),
        .DataBuff(DataBuff), .WrBuff(WrBuff), .FlagDetect(FlagDetect),
        .EoF(EoF), .FrameError(FrameError), .AbortedFrame(AbortedFrame),
        .Active(Active)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int nchk = 0;
    int nerr = 0;

    // Monitor state
    logic [7:0] got_q[$];
    int n_eof, n_ferr, n_abort, n_flag;
    int bad_timing = 0;
    int excl = 0;
    logic flag_prev = 1'b0;

    always @(negedge Clk) begin
        if (WrBuff === 1'b1) got_q.push_back(DataBuff);
        if (EoF === 1'b1) n_eof++;
        if (FrameError === 1'b1) n_ferr++;
        if (AbortedFrame === 1'b1) n_abort++;
        if (FlagDetect === 1'b1) n_flag++;
        if (((EoF === 1'b1) || (FrameError === 1'b1)) && !flag_prev) bad_timing++;
        if (((EoF === 1'b1) || (FrameError === 1'b1)) && (WrBuff === 1'b1)) bad_timing++;
        if (int'(EoF === 1'b1) + int'(FrameError === 1'b1) + int'(AbortedFrame === 1'b1) > 1) excl++;
        flag_prev = (FlagDetect === 1'b1);
    end

    task automatic clr_mon();
        got_q.delete();
        n_eof = 0; n_ferr = 0; n_abort = 0; n_flag = 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_bytes(input string nm, input logic [7:0] exp[$]);
        chk({nm, ".count"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < got_q.size())
                chk($sformatf("%s.byte%0d", nm, i), int'(got_q[i]), int'(exp[i]));
    endtask

    // Transmit side: serial bit queue with zero insertion
    logic bitq[$];
    int   ones_tx = 0;

    task automatic tx_bits(input logic [7:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            bitq.push_back(val[i]);
            if (val[i]) begin
                ones_tx++;
                if (ones_tx == 5) begin
                    bitq.push_back(1'b0);
                    ones_tx = 0;
                end
            end else begin
                ones_tx = 0;
            end
        end
    endtask

    task automatic tx_flag();
        logic [7:0] fl;
        fl = 8'h7E;
        for (int i = 0; i < 8; i++) bitq.push_back(fl[i]);
        ones_tx = 0;
    endtask

    task automatic tx_raw(input logic b, input int n);
        for (int i = 0; i < n; i++) bitq.push_back(b);
        ones_tx = 0;
    endtask

    task automatic run_q(input bit toggle);
        logic b;
        while (bitq.size() > 0) begin
            b = bitq.pop_front();
            @(posedge Clk); #1;
            RxEn = 1'b1; Rx = b;
            if (toggle) begin
                @(posedge Clk); #1;
                RxEn = 1'b0; Rx = ~b;
            end
        end
        @(posedge Clk); #1;
        RxEn = 1'b0; Rx = 1'b0;
        repeat (4) @(posedge Clk);
    endtask

    function automatic logic [15:0] fcs_of(input logic [7:0] d[$]);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = 0; i < d.size(); i++)
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ d[i][k];
                c = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        return ~c;
    endfunction

    task automatic add_fcs(inout logic [7:0] q[$], input bit corrupt);
        logic [15:0] f;
        f = fcs_of(q);
        if (corrupt) f[7:0] = f[7:0] ^ 8'h01;
        q.push_back(f[7:0]);
        q.push_back(f[15:8]);
    endtask

    typedef struct {
        string       name;
        int          nb;
        logic [63:0] data;
        bit          fcs;
        bit          corrupt;
        int          xbits;
        logic [7:0]  xval;
        int          eof;
        int          ferr;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [7:0] dq[$];
        logic [7:0] eq[$];

        vt[0] = '{"valid",      3, 64'h7E3CA5,  1'b1, 1'b0, 0, 8'h00, 1, 0};
        vt[1] = '{"destuff",    2, 64'hFFFF,    1'b1, 1'b0, 0, 8'h00, 1, 0};
        vt[2] = '{"short",      2, 64'h2211,    1'b0, 1'b0, 0, 8'h00, 0, 1};
        vt[3] = '{"align",      3, 64'h555555,  1'b0, 1'b0, 3, 8'h05, 0, 1};
`ifdef RX_FCS_CHECK_EN
        vt[4] = '{"badfcs",     3, 64'h7E3CA5,  1'b1, 1'b1, 0, 8'h00, 0, 1};
`else
        vt[4] = '{"badfcs",     3, 64'h7E3CA5,  1'b1, 1'b1, 0, 8'h00, 1, 0};
`endif
        vt[5] = '{"minlen",     1, 64'hC3,      1'b1, 1'b0, 0, 8'h00, 1, 0};
        vt[6] = '{"flaglike",   2, 64'h7E7E,    1'b1, 1'b0, 0, 8'h00, 1, 0};
        vt[7] = '{"crossstuff", 2, 64'h0FF8,    1'b1, 1'b0, 0, 8'h00, 1, 0};

        Rst = 1'b0; RxEn = 1'b0; Rx = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset.outs", int'({DataBuff, WrBuff, FlagDetect, EoF, FrameError, AbortedFrame, Active}), 0);
        @(posedge Clk); #1;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);

        // Table-driven single frames
        for (int v = 0; v < 8; v++) begin
            clr_mon();
            dq.delete();
            for (int i = 0; i < vt[v].nb; i++) dq.push_back(vt[v].data[8*i +: 8]);
            if (vt[v].fcs) add_fcs(dq, vt[v].corrupt);
            tx_raw(1'b1, 8);
            tx_flag();
            foreach (dq[i]) tx_bits(dq[i], 8);
            if (vt[v].xbits > 0) tx_bits(vt[v].xval, vt[v].xbits);
            tx_flag();
            tx_raw(1'b1, 8);
            run_q(1'b0);
            chk_bytes(vt[v].name, dq);
            chk({vt[v].name, ".eof"},   n_eof,   vt[v].eof);
            chk({vt[v].name, ".ferr"},  n_ferr,  vt[v].ferr);
            chk({vt[v].name, ".abort"}, n_abort, 0);
            chk({vt[v].name, ".flags"}, n_flag,  2);
        end

        // Abort inside a frame
        clr_mon();
        tx_raw(1'b1, 8);
        tx_flag();
        tx_bits(8'h55, 8);
        tx_raw(1'b1, 7);
        run_q(1'b0);
        @(negedge Clk);
        chk("abort.pulse",  n_abort, 1);
        chk("abort.eof",    n_eof + n_ferr, 0);
        chk("abort.active", int'(Active), 0);
        chk("abort.bytes",  got_q.size(), 0);

        // Garbage after abort must not produce bytes
        clr_mon();
        tx_raw(1'b0, 12);
        tx_bits(8'h12, 8);
        tx_bits(8'hC4, 8);
        run_q(1'b0);
        chk("postabort.bytes", got_q.size(), 0);
        chk("postabort.pulses", n_eof + n_ferr + n_abort, 0);

        // Valid frame after abort
        clr_mon();
        dq.delete();
        dq.push_back(8'hA5); dq.push_back(8'h3C); dq.push_back(8'h7E);
        add_fcs(dq, 1'b0);
        tx_flag();
        foreach (dq[i]) tx_bits(dq[i], 8);
        tx_flag();
        tx_raw(1'b1, 8);
        run_q(1'b0);
        chk_bytes("recover", dq);
        chk("recover.eof", n_eof, 1);
        chk("recover.ferr", n_ferr, 0);

        // Back-to-back frames sharing a flag, RxEn steady then gapped
        for (int t = 0; t < 2; t++) begin
            clr_mon();
            dq.delete();
            dq.push_back(8'hA5); dq.push_back(8'h3C); dq.push_back(8'h7E);
            add_fcs(dq, 1'b0);
            eq.delete();
            eq.push_back(8'h11); eq.push_back(8'h22); eq.push_back(8'h33);
            add_fcs(eq, 1'b0);
            tx_raw(1'b1, 8);
            tx_flag();
            foreach (dq[i]) tx_bits(dq[i], 8);
            tx_flag();
            foreach (eq[i]) tx_bits(eq[i], 8);
            tx_flag();
            tx_raw(1'b1, 8);
            foreach (eq[i]) dq.push_back(eq[i]);
            run_q(t == 1);
            chk_bytes($sformatf("b2b%0d", t), dq);
            chk($sformatf("b2b%0d.eof", t),  n_eof,  2);
            chk($sformatf("b2b%0d.ferr", t), n_ferr, 0);
        end

        // Reset in the middle of a frame
        clr_mon();
        tx_raw(1'b1, 8);
        tx_flag();
        tx_bits(8'hA5, 8);
        tx_bits(8'h3C, 8);
        run_q(1'b0);
        @(negedge Clk);
        chk("rstmid.active", int'(Active), 1);
        chk("rstmid.pre_bytes", got_q.size(), 1);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("rstmid.outs", int'({DataBuff, WrBuff, FlagDetect, EoF, FrameError, AbortedFrame, Active}), 0);
        @(posedge Clk); #1;
        Rst = 1'b1;
        clr_mon();
        tx_bits(8'h7E, 8);
        tx_bits(8'h9D, 8);
        tx_bits(8'h41, 8);
        tx_flag();
        tx_raw(1'b1, 8);
        run_q(1'b0);
        chk("rstmid.post_bytes", got_q.size(), 0);
        chk("rstmid.post_pulses", n_eof + n_ferr + n_abort, 0);

        chk("timing", bad_timing, 0);
        chk("exclusive", excl, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
